// File: rtl/interrupt_controller.sv
// Timer interrupt controller: accepts one enabled timer request at an instruction
// boundary, pushes the 14-bit return PC (low byte first), then loads the vector.
module interrupt_controller #(
  parameter logic [13:0] VEC_OCF1A = 14'h00E,
  parameter logic [13:0] VEC_TOV1  = 14'h012,
  parameter logic [13:0] VEC_OCF0  = 14'h014,
  parameter logic [13:0] VEC_TOV0  = 14'h016
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  tifr,
  input  logic [7:0]  timsk,
  input  logic        sreg_i,
  input  logic        boundary,
  input  logic [13:0] pc,
  input  logic [15:0] sp,
  output logic        irq_pending,
  output logic        busy,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        sp_dec,
  output logic        pc_load,
  output logic [13:0] pc_vector,
  output logic        clear_i,
  output logic [7:0]  flag_clear
);

  typedef enum logic [1:0] {IDLE, PUSH_LO, PUSH_HI, VECTOR} state_t;

  state_t      state_q, state_d;
  logic [13:0] ret_pc_q, ret_pc_d;
  logic [15:0] sp_lat_q, sp_lat_d;
  logic [7:0]  win_q, win_d;
  logic [7:0]  req;
  logic [7:0]  winner;
  logic [13:0] win_vec;
  logic        accept;

  assign req         = tifr & timsk & 8'b0001_0111;
  assign irq_pending = (|req) & sreg_i & (state_q == IDLE);
  assign accept      = irq_pending & boundary;

  // Fixed priority, lowest vector address wins; winner kept one-hot.
  always_comb begin
    winner = '0;
    if (req[4])      winner = 8'h10;
    else if (req[2]) winner = 8'h04;
    else if (req[1]) winner = 8'h02;
    else if (req[0]) winner = 8'h01;
  end

  always_comb begin
    win_vec = '0;
    case (win_q)
      8'h10:   win_vec = VEC_OCF1A;
      8'h04:   win_vec = VEC_TOV1;
      8'h02:   win_vec = VEC_OCF0;
      8'h01:   win_vec = VEC_TOV0;
      default: win_vec = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ret_pc_q <= '0;
      sp_lat_q <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      ret_pc_q <= ret_pc_d;
      sp_lat_q <= sp_lat_d;
      win_q    <= win_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_pc_d   = ret_pc_q;
    sp_lat_d   = sp_lat_q;
    win_d      = win_q;
    busy       = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    sp_dec     = 1'b0;
    pc_load    = 1'b0;
    pc_vector  = '0;
    clear_i    = 1'b0;
    flag_clear = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = PUSH_LO;
          ret_pc_d = pc;
          sp_lat_d = sp;
          win_d    = winner;
        end
      end
      PUSH_LO: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_lat_q;
        mem_wdata = ret_pc_q[7:0];
        sp_dec    = 1'b1;
        state_d   = PUSH_HI;
      end
      PUSH_HI: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_lat_q - 16'd1;
        mem_wdata = {2'b00, ret_pc_q[13:8]};
        sp_dec    = 1'b1;
        state_d   = VECTOR;
      end
      VECTOR: begin
        busy       = 1'b1;
        pc_load    = 1'b1;
        pc_vector  = win_vec;
        clear_i    = 1'b1;
        flag_clear = win_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: expected per-cycle output bundles are
// queued at acceptance and compared as the entry sequence runs.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tifr, timsk;
  logic        sreg_i, boundary;
  logic [13:0] pc;
  logic [15:0] sp;
  logic        irq_pending, busy, mem_we, sp_dec, pc_load, clear_i;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, flag_clear;
  logic [13:0] pc_vector;

  int passed = 0;
  int total  = 0;
  logic [50:0] q[$];
  logic [50:0] obs, expv;
  int seen_we, seen_ip;

  always #5 clk = ~clk;

  interrupt_controller #(
    .VEC_OCF1A(14'h00E), .VEC_TOV1(14'h012), .VEC_OCF0(14'h014), .VEC_TOV0(14'h016)
  ) dut (
    .clk(clk), .rst(rst), .tifr(tifr), .timsk(timsk), .sreg_i(sreg_i),
    .boundary(boundary), .pc(pc), .sp(sp), .irq_pending(irq_pending), .busy(busy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .sp_dec(sp_dec),
    .pc_load(pc_load), .pc_vector(pc_vector), .clear_i(clear_i), .flag_clear(flag_clear)
  );

  assign obs = {mem_we, mem_addr, mem_wdata, sp_dec, pc_load, pc_vector, clear_i, flag_clear, busy};

  function automatic logic [50:0] mk(input logic we, input logic [15:0] a, input logic [7:0] d,
                                     input logic dec, input logic ld, input logic [13:0] v,
                                     input logic ci, input logic [7:0] fc, input logic b);
    return {we, a, d, dec, ld, v, ci, fc, b};
  endfunction

  // Reference priority/vector table: {vector, one-hot flag}.
  function automatic logic [21:0] ref_win(input logic [7:0] t, input logic [7:0] m);
    logic [7:0] r;
    r = t & m;
    if (r[4])      return {14'h00E, 8'h10};
    else if (r[2]) return {14'h012, 8'h04};
    else if (r[1]) return {14'h014, 8'h02};
    else if (r[0]) return {14'h016, 8'h01};
    return '0;
  endfunction

  task automatic push_seq(input logic [13:0] p, input logic [15:0] s, input logic [21:0] w);
    q.push_back(mk(1'b1, s, p[7:0], 1'b1, 1'b0, 14'h0, 1'b0, 8'h00, 1'b1));
    q.push_back(mk(1'b1, s - 16'd1, {2'b00, p[13:8]}, 1'b1, 1'b0, 14'h0, 1'b0, 8'h00, 1'b1));
    q.push_back(mk(1'b0, 16'h0, 8'h00, 1'b0, 1'b1, w[21:8], 1'b1, w[7:0], 1'b1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tifr = 8'h00; timsk = 8'h00; sreg_i = 1'b0; boundary = 1'b0;
    pc = '0; sp = '0;
    tick(); tick();
    total++;
    if ({irq_pending, obs} !== 52'h0) $display("FAIL reset_outputs got=%h exp=0", {irq_pending, obs});
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    tifr = 8'h01; timsk = 8'h01; sreg_i = 1'b1; pc = 14'h0123; sp = 16'h085F;
    #1;
    total++;
    if (irq_pending !== 1'b1) $display("FAIL single_pending got=%b exp=1", irq_pending);
    else passed++;
    boundary = 1'b1;
    push_seq(pc, sp, ref_win(tifr, timsk));
    for (int c = 0; c < 3; c++) begin
      tick();
      boundary = 1'b0;
      pc = 14'h2AAA; sp = 16'h1234;  // must not disturb the latched values
      expv = q.pop_front();
      total++;
      if (obs !== expv) $display("FAIL single_cycle%0d got=%h exp=%h", c + 1, obs, expv);
      else passed++;
    end
    tick();
    total++;
    if (obs !== 51'h0) $display("FAIL single_idle got=%h exp=0", obs);
    else passed++;
    tifr = 8'h00;
    tick();
  endtask

  task automatic test_priority();
    tifr = 8'h17; timsk = 8'hFF; sreg_i = 1'b1; pc = 14'h0456; sp = 16'h0800;
    boundary = 1'b1;  // held high throughout: no re-acceptance while busy
    push_seq(pc, sp, ref_win(tifr, timsk));
    for (int c = 0; c < 3; c++) begin
      tick();
      expv = q.pop_front();
      total++;
      if (obs !== expv) $display("FAIL prio_cycle%0d got=%h exp=%h", c + 1, obs, expv);
      else passed++;
    end
    boundary = 1'b0;
    tick();
    total++;
    if ({busy, irq_pending} !== 2'b01) $display("FAIL prio_reeval got=%b exp=01", {busy, irq_pending});
    else passed++;
    tifr = 8'h07;  // OCF1A serviced; remaining flags still pending
    boundary = 1'b1;
    push_seq(pc, sp, ref_win(tifr, timsk));
    for (int c = 0; c < 3; c++) begin
      tick();
      boundary = 1'b0;
      expv = q.pop_front();
      total++;
      if (obs !== expv) $display("FAIL prio2_cycle%0d got=%h exp=%h", c + 1, obs, expv);
      else passed++;
    end
    tifr = 8'h00;
    tick();
  endtask

  task automatic test_masking();
    for (int k = 0; k < 2; k++) begin
      tifr = 8'h02;
      timsk = (k == 0) ? 8'h00 : 8'hFF;
      sreg_i = (k == 0) ? 1'b1 : 1'b0;
      seen_we = 0; seen_ip = 0;
      for (int c = 0; c < 20; c++) begin
        boundary = (c % 2 == 0);
        tick();
        if (mem_we) seen_we++;
        if (irq_pending) seen_ip++;
      end
      total++;
      if (seen_we !== 0) $display("FAIL mask%0d_we got=%0d exp=0", k, seen_we);
      else passed++;
      total++;
      if (seen_ip !== 0) $display("FAIL mask%0d_pending got=%0d exp=0", k, seen_ip);
      else passed++;
    end
    boundary = 1'b0;
    tifr = 8'h01; timsk = 8'h01; sreg_i = 1'b1;
    tick();
    tifr = 8'h00;  // request withdrawn before the boundary arrives
    boundary = 1'b1;
    tick();
    boundary = 1'b0;
    total++;
    if (busy !== 1'b0 || mem_we !== 1'b0) $display("FAIL req_drop got=%b%b exp=00", busy, mem_we);
    else passed++;
    tick();
  endtask

  task automatic test_wrap();
    tifr = 8'h02; timsk = 8'h02; sreg_i = 1'b1; pc = 14'h3FFF; sp = 16'h0000;
    boundary = 1'b1;
    push_seq(pc, sp, ref_win(tifr, timsk));
    for (int c = 0; c < 3; c++) begin
      tick();
      boundary = 1'b0;
      expv = q.pop_front();
      total++;
      if (obs !== expv) $display("FAIL wrap_cycle%0d got=%h exp=%h", c + 1, obs, expv);
      else passed++;
    end
    tifr = 8'h00;
    tick();
  endtask

  task automatic test_reset_mid();
    tifr = 8'h01; timsk = 8'h01; sreg_i = 1'b1; pc = 14'h1357; sp = 16'h0400;
    boundary = 1'b1;
    push_seq(pc, sp, ref_win(tifr, timsk));
    for (int c = 0; c < 2; c++) begin
      tick();
      boundary = 1'b0;
      expv = q.pop_front();
      total++;
      if (obs !== expv) $display("FAIL rstmid_cycle%0d got=%h exp=%h", c + 1, obs, expv);
      else passed++;
    end
    rst = 1'b1;  // asserted while in PUSH_HI
    q.delete();
    tick();
    rst = 1'b0;
    total++;
    if (obs !== 51'h0) $display("FAIL rstmid_outputs got=%h exp=0", obs);
    else passed++;
    total++;
    if (irq_pending !== 1'b1) $display("FAIL rstmid_pending got=%b exp=1", irq_pending);
    else passed++;
    tick();
    total++;
    if (busy !== 1'b0) $display("FAIL rstmid_noresume got=%b exp=0", busy);
    else passed++;
    boundary = 1'b1;
    push_seq(pc, sp, ref_win(tifr, timsk));
    for (int c = 0; c < 3; c++) begin
      tick();
      boundary = 1'b0;
      expv = q.pop_front();
      total++;
      if (obs !== expv) $display("FAIL restart_cycle%0d got=%h exp=%h", c + 1, obs, expv);
      else passed++;
    end
    tifr = 8'h00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_masking();
    test_wrap();
    test_reset_mid();
    total++;
    if (q.size() !== 0) $display("FAIL scoreboard_leftover got=%0d exp=0", q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
